// File: rtl/rv32_mem_arbiter.sv
// Arbitrates one single-ported memory bus between instruction fetch and data ports.
// Define RV32_MEM_ARB_PERF_EN to build the grant/conflict performance counters.
module rv32_mem_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int DATA_STREAK_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req_valid,
    input  logic [ADDR_W-1:0]   i_req_addr,
    output logic                i_done,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req_valid,
    input  logic                d_req_we,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic [DATA_W-1:0]   d_req_wdata,
    input  logic [DATA_W/8-1:0] d_req_wstrb,
    output logic                d_done,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_req_valid,
    output logic                m_req_we,
    output logic [ADDR_W-1:0]   m_req_addr,
    output logic [DATA_W-1:0]   m_req_wdata,
    output logic [DATA_W/8-1:0] m_req_wstrb,
    input  logic                m_done,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic [31:0]         perf_i_grants,
    output logic [31:0]         perf_d_grants,
    output logic [31:0]         perf_conflict_cycles
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT_I = 2'd1;
    localparam logic [1:0] GRANT_D = 2'd2;
    localparam logic [3:0] STREAK_MAX = 4'(DATA_STREAK_MAX);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [3:0] streak;
    logic       enter_i;
    logic       enter_d;
    logic       own_i;
    logic       own_d;

    // Data wins unless fetch has already waited through STREAK_MAX data grants.
    always_comb begin
        enter_d = (state == IDLE) && d_req_valid && (!i_req_valid || (streak < STREAK_MAX));
        enter_i = (state == IDLE) && i_req_valid && !enter_d;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enter_d) begin
                    state_nxt = GRANT_D;
                end else if (enter_i) begin
                    state_nxt = GRANT_I;
                end
            end
            GRANT_I, GRANT_D: begin
                if (m_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            streak <= 4'd0;
        end else begin
            state <= state_nxt;
            if (enter_d) begin
                if (!i_req_valid) begin
                    streak <= 4'd0;
                end else if (streak != STREAK_MAX) begin
                    streak <= streak + 4'd1;
                end
            end else if (enter_i) begin
                streak <= 4'd0;
            end
        end
    end

    // Reset gates ownership so an abandoned transaction never reaches the bus or a requester.
    assign own_i = (state == GRANT_I) && !reset;
    assign own_d = (state == GRANT_D) && !reset;

    always_comb begin
        m_req_valid = 1'b0;
        m_req_we    = 1'b0;
        m_req_addr  = '0;
        m_req_wdata = '0;
        m_req_wstrb = '0;
        i_done      = 1'b0;
        i_rdata     = '0;
        d_done      = 1'b0;
        d_rdata     = '0;
        if (own_i) begin
            m_req_valid = 1'b1;
            m_req_addr  = i_req_addr;
            i_done      = m_done;
            i_rdata     = m_done ? m_rdata : '0;
        end else if (own_d) begin
            m_req_valid = 1'b1;
            m_req_we    = d_req_we;
            m_req_addr  = d_req_addr;
            m_req_wdata = d_req_wdata;
            m_req_wstrb = d_req_wstrb;
            d_done      = m_done;
            d_rdata     = m_done ? m_rdata : '0;
        end
    end

`ifdef RV32_MEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_i_grants        <= 32'd0;
            perf_d_grants        <= 32'd0;
            perf_conflict_cycles <= 32'd0;
        end else begin
            if (enter_i) begin
                perf_i_grants <= perf_i_grants + 32'd1;
            end
            if (enter_d) begin
                perf_d_grants <= perf_d_grants + 32'd1;
            end
            if (i_req_valid && d_req_valid) begin
                perf_conflict_cycles <= perf_conflict_cycles + 32'd1;
            end
        end
    end
`else
    assign perf_i_grants        = 32'd0;
    assign perf_d_grants        = 32'd0;
    assign perf_conflict_cycles = 32'd0;
`endif

endmodule

// File: doc/rv32_mem_arbiter.md
Name: rv32_mem_arbiter

Overview:
- Shares one single-ported memory bus between the core's instruction fetch port and data (MEM stage) port.
- Sits between the rv32 core and the unified RAM/bus.
- Requesters hold their request until they see a one-cycle done. The arbiter forwards exactly one request at a time and routes the done pulse and read data back to the owner.
- Data requests have priority, with a bounded starvation guard for fetch.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- DATA_STREAK_MAX, 4, max consecutive data grants while a fetch request is pending (legal 1..15)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_req_valid  in  1  instruction request pending (held until i_done)
- i_req_addr  in  ADDR_W  instruction fetch address
- i_done  out  1  one-cycle completion pulse to fetch
- i_rdata  out  DATA_W  fetched word, valid when i_done=1
- d_req_valid  in  1  data request pending (held until d_done)
- d_req_we  in  1  1 = store, 0 = load
- d_req_addr  in  ADDR_W  data address
- d_req_wdata  in  DATA_W  store data
- d_req_wstrb  in  DATA_W/8  byte strobes
- d_done  out  1  one-cycle completion pulse to MEM stage
- d_rdata  out  DATA_W  load data, valid when d_done=1
- m_req_valid  out  1  request to memory
- m_req_we  out  1  write enable
- m_req_addr  out  ADDR_W  address
- m_req_wdata  out  DATA_W  write data
- m_req_wstrb  out  DATA_W/8  strobes (all zeros for fetch)
- m_done  in  1  memory completion pulse
- m_rdata  in  DATA_W  memory read data
- perf_i_grants  out  32  fetch grants count (optional feature)
- perf_d_grants  out  32  data grants count (optional feature)
- perf_conflict_cycles  out  32  cycles with both requests pending (optional feature)

Behaviour:
- States: IDLE, GRANT_I, GRANT_D. State, streak counter and perf counters are registered.
- Reset: state=IDLE, streak=0, perf counters=0. Every output is 0 during and after reset until a grant.
- IDLE, arbitration:
  - d only -> GRANT_D.
  - i only -> GRANT_I.
  - Both, streak < DATA_STREAK_MAX -> GRANT_D.
  - Both, streak == DATA_STREAK_MAX -> GRANT_I.
  - Neither -> stay in IDLE.
- GRANT_x:
  - m_req_* = owner's request fields, muxed combinationally from the live inputs.
  - m_req_valid=1. For fetch, m_req_we=0 and m_req_wstrb=0.
  - Hold the state until m_done=1.
  - On m_done: x_done=1 and x_rdata=m_rdata in the same cycle (combinational), and the other port's done stays 0. Next state is IDLE.
- Latency:
  - Request first seen in IDLE at cycle N -> m_req_valid at N+1.
  - m_done at M -> owner done at M; next grant visible on the memory bus no earlier than M+2 (one IDLE cycle).
- Outside GRANT: m_req_valid=0, both done=0, and rdata outputs and m_req_* payload are driven to 0.
- Streak counter:
  - Increments on each entry to GRANT_D while i_req_valid=1, saturating at DATA_STREAK_MAX.
  - Clears on entry to GRANT_I, or on entry to GRANT_D with i_req_valid=0.
- m_done while in IDLE: ignored, no done generated.
- Requester dropping valid mid-grant is a protocol violation. The grant still holds until m_done; the payload follows the live inputs.
- Reset mid-grant: back to IDLE next cycle, m_req_valid=0, no done issued. The memory must abandon the transaction.
- Single-cycle memory (m_done in the first grant cycle) is legal.

Optional Feature:
- Macro: RV32_MEM_ARB_PERF_EN.
- Defined:
  - perf_i_grants / perf_d_grants increment on each entry to GRANT_I / GRANT_D.
  - perf_conflict_cycles increments on every cycle with i_req_valid & d_req_valid.
  - All wrap at 2^32 and clear on reset.
- Undefined: the three perf ports remain present, tied to 0, with no counter registers.

Test Plan:
- Fetch only, addr 0x100, memory done after 2 grant cycles with rdata 0x00000013 -> m_req_valid rises 1 cycle after i_req_valid; i_done=1 with i_rdata=0x13 on the m_done cycle; d_done never asserts.
- Both valid from reset release, each memory access 1 cycle -> order D,D,D,D,I,D... with DATA_STREAK_MAX=4; perf_conflict_cycles matches the count of overlap cycles (PERF_EN).
- Store d addr 0x2000, wdata 0xDEADBEEF, wstrb 0b0011 -> m_req_we=1 and payload passed through exactly; d_done on m_done; i_rdata stays 0.
- Reset asserted in GRANT_D before m_done -> m_req_valid=0 the next cycle, no d_done, perf counters 0, state IDLE.
- Spurious m_done in IDLE -> no i_done or d_done; state stays IDLE.
- Macro undefined, 10 grants -> all perf ports read 0.
